iq_packet_splitter: RTL
=======================

Name: iq_packet_splitter

Overview:
AXI-Stream slave front end that feeds the in-phase/quadrature component FSM pair. It accepts TDATA words and splits each into an in-phase half (even bits) and a quadrature half (odd bits). Each half is double-buffered per branch. The block presents the bit currently selected by each FSM's data counter, drives start_fsms and the per-branch last-packet flags, and hands the next packet over on each receive_data pulse.

Parameters:
C_S00_AXIS_TDATA_WIDTH, 16, stream word width; must be even, ≥4; each branch packet is C_S00_AXIS_TDATA_WIDTH/2 bits (HW below).

Ports:
aclk  in  1  single clock
sresetn  in  1  synchronous active-low reset
s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  symbol bits
s00_axis_tvalid  in  1  AXIS valid
s00_axis_tready  out  1  AXIS ready
s00_axis_tlast  in  1  marks final word of transmission
inphase_receive_data  in  1  pulse: in-phase FSM consumed current packet
quadrature_receive_data  in  1  pulse: quadrature FSM consumed current packet
inphase_data_counter  in  $clog2(HW)  in-phase bit index
quadrature_data_counter  in  $clog2(HW)  quadrature bit index
end_of_transmission  in  1  both FSMs finished
start_fsms  out  1  one-cycle start pulse
last_inphase_packet  out  1  current in-phase packet is final
last_quadrature_packet  out  1  current quadrature packet is final
inphase_bit  out  1  cur_i[inphase_data_counter]
quadrature_bit  out  1  cur_q[quadrature_data_counter]
underrun  out  1  sticky: receive pulse with no packet available

Behaviour:
- Bit split: word bit 2k -> in-phase bit k; word bit 2k+1 -> quadrature bit k; k = 0..HW-1.
- Per-branch storage: cur_x[HW], cur_last_x, nxt_x[HW], nxt_valid_x, nxt_last_x (x = i, q).
- inphase_bit and quadrature_bit are combinational selects of cur_x. last_*_packet = cur_last_x.
- States:
  - IDLE: tready=1. Handshake loads both cur_x and cur_last_x from the word, clears underrun, then goes to PRIMED.
  - PRIMED: start_fsms=1 for exactly this cycle. Next state is DRAIN if cur_last set, else RUN.
  - RUN: tready = !nxt_valid_i && !nxt_valid_q. A handshake fills both nxt halves and sets both nxt_valid bits and both nxt_last bits. After accepting a word with tlast, go to DRAIN.
  - DRAIN: tready=0. On end_of_transmission, go to IDLE.
  - end_of_transmission in any non-IDLE state forces IDLE and clears all valid/last bits on the next edge.
- Receive pulse on branch x, RUN or DRAIN:
  - If nxt_valid_x: cur_x <= nxt_x, cur_last_x <= nxt_last_x, nxt_valid_x <= 0.
  - Else, if a handshake occurs in the same cycle: bypass. cur_x and cur_last_x load directly from the incoming word; nxt_valid_x stays 0; the other branch's nxt is still filled.
  - Else: cur_x holds, underrun <= 1.
  - Receive pulse while cur_last_x = 1 is ignored, with no underrun.
- Receive pulses in IDLE or PRIMED are ignored.
- The branches advance independently; quadrature lags by half a symbol. tready waits for both nxt slots to be empty.
- Latency: first-word handshake to start_fsms = 1 cycle. Handshake to nxt_valid = 1 cycle.
- Reset values: tready=0 during reset, 1 in the cycle after reset (IDLE). start_fsms=0, last_*=0, *_bit=0 (cur cleared), underrun=0, all valid bits 0.
- Reset mid-operation: all state is discarded; the partially received word is dropped. tvalid held high across reset is accepted in the first IDLE cycle.

Test Plan:
- Single word 0xA5C3 with tlast=1 -> cur_i=0x39, cur_q=0xC9; start_fsms pulses once 1 cycle after handshake; both last flags =1; tready=0 until end_of_transmission; IDLE follows.
- Three words 0x0001, 0x0002, 0x0003 (last on third), FSMs pulse receive every 8 counts -> inphase_bit sequence 1,0..0 | 0..0 | 1,0..0; quadrature sees 0 | 1,0..0 | 1,0..0; last flags rise only with the third packet.
- Backpressure: tvalid continuous, no receive pulses after priming -> exactly one word accepted into nxt, tready=0 thereafter; the word is held without loss until receive pulses on both branches.
- Underrun: prime with a non-last word, tvalid=0, inphase_receive_data pulse -> underrun=1, cur_i unchanged; underrun stays 1 until the next IDLE handshake.
- Bypass: nxt empty, inphase_receive_data coincides with handshake of 0xFFFF -> cur_i=0xFF next cycle, nxt_valid_i=0, nxt_valid_q=1, underrun=0.
- Reset asserted in RUN with nxt_valid=1 -> all outputs at reset values next cycle; a fresh word primes normally with a single start_fsms pulse.

Source files
------------

// File: rtl/iq_packet_splitter.sv
`timescale 1ns/100ps
// AXI-Stream front end: splits each word into an in-phase packet (even bits) and a
// quadrature packet (odd bits), double-buffered per branch for the component FSM pair.
module iq_packet_splitter #(
  parameter  int C_S00_AXIS_TDATA_WIDTH = 16,
  localparam int HW = C_S00_AXIS_TDATA_WIDTH / 2,
  localparam int CW = $clog2(HW)
) (
  input  logic                              aclk,
  input  logic                              sresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tvalid,
  output logic                              s00_axis_tready,
  input  logic                              s00_axis_tlast,
  input  logic                              inphase_receive_data,
  input  logic                              quadrature_receive_data,
  input  logic [CW-1:0]                     inphase_data_counter,
  input  logic [CW-1:0]                     quadrature_data_counter,
  input  logic                              end_of_transmission,
  output logic                              start_fsms,
  output logic                              last_inphase_packet,
  output logic                              last_quadrature_packet,
  output logic                              inphase_bit,
  output logic                              quadrature_bit,
  output logic                              underrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIMED = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [HW-1:0] cur_i;
  logic [HW-1:0] cur_q;
  logic [HW-1:0] nxt_i;
  logic [HW-1:0] nxt_q;
  logic          cur_last_i;
  logic          cur_last_q;
  logic          nxt_valid_i;
  logic          nxt_valid_q;
  logic          nxt_last_i;
  logic          nxt_last_q;

  logic          ready;
  logic          handshake;
  logic          streaming;
  logic [HW-1:0] word_i;
  logic [HW-1:0] word_q;

  function automatic logic [HW-1:0] split_half(input logic [C_S00_AXIS_TDATA_WIDTH-1:0] word,
                                               input logic odd);
    logic [HW-1:0] half;
    half = '0;
    for (int k = 0; k < HW; k++) begin
      half[k] = odd ? word[2*k+1] : word[2*k];
    end
    return half;
  endfunction

  assign word_i    = split_half(s00_axis_tdata, 1'b0);
  assign word_q    = split_half(s00_axis_tdata, 1'b1);
  assign streaming = (state == S_RUN) || (state == S_DRAIN);

  // State register
  always_ff @(posedge aclk) begin
    if (!sresetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Ready, handshake and next-state decode; ready is held low while in reset
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    handshake  = 1'b0;
    case (state)
      S_IDLE:  ready = sresetn;
      S_RUN:   ready = sresetn && !nxt_valid_i && !nxt_valid_q;
      default: ready = 1'b0;
    endcase
    handshake = s00_axis_tvalid && ready;
    case (state)
      S_IDLE: begin
        if (handshake) next_state = S_PRIMED;
        else           next_state = S_IDLE;
      end
      S_PRIMED: begin
        if (end_of_transmission) next_state = S_IDLE;
        else if (cur_last_i)     next_state = S_DRAIN;
        else                     next_state = S_RUN;
      end
      S_RUN: begin
        if (end_of_transmission)            next_state = S_IDLE;
        else if (handshake && s00_axis_tlast) next_state = S_DRAIN;
        else                                next_state = S_RUN;
      end
      S_DRAIN: begin
        if (end_of_transmission) next_state = S_IDLE;
        else                     next_state = S_DRAIN;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Per-branch double buffers, bypass path and sticky underrun flag
  always_ff @(posedge aclk) begin
    if (!sresetn) begin
      cur_i       <= '0;
      cur_q       <= '0;
      nxt_i       <= '0;
      nxt_q       <= '0;
      cur_last_i  <= 1'b0;
      cur_last_q  <= 1'b0;
      nxt_valid_i <= 1'b0;
      nxt_valid_q <= 1'b0;
      nxt_last_i  <= 1'b0;
      nxt_last_q  <= 1'b0;
      underrun    <= 1'b0;
    end else if ((state != S_IDLE) && end_of_transmission) begin
      cur_last_i  <= 1'b0;
      cur_last_q  <= 1'b0;
      nxt_valid_i <= 1'b0;
      nxt_valid_q <= 1'b0;
      nxt_last_i  <= 1'b0;
      nxt_last_q  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (handshake) begin
        cur_i      <= word_i;
        cur_q      <= word_q;
        cur_last_i <= s00_axis_tlast;
        cur_last_q <= s00_axis_tlast;
        underrun   <= 1'b0;
      end
    end else if (streaming) begin
      // A consume pulse on a branch already holding its final packet is ignored
      if (inphase_receive_data && !cur_last_i) begin
        if (nxt_valid_i) begin
          cur_i       <= nxt_i;
          cur_last_i  <= nxt_last_i;
          nxt_valid_i <= 1'b0;
        end else if (handshake) begin
          cur_i      <= word_i;
          cur_last_i <= s00_axis_tlast;
        end else begin
          underrun <= 1'b1;
        end
      end else if (handshake) begin
        nxt_i       <= word_i;
        nxt_valid_i <= 1'b1;
        nxt_last_i  <= s00_axis_tlast;
      end

      if (quadrature_receive_data && !cur_last_q) begin
        if (nxt_valid_q) begin
          cur_q       <= nxt_q;
          cur_last_q  <= nxt_last_q;
          nxt_valid_q <= 1'b0;
        end else if (handshake) begin
          cur_q      <= word_q;
          cur_last_q <= s00_axis_tlast;
        end else begin
          underrun <= 1'b1;
        end
      end else if (handshake) begin
        nxt_q       <= word_q;
        nxt_valid_q <= 1'b1;
        nxt_last_q  <= s00_axis_tlast;
      end
    end
  end

  assign s00_axis_tready        = ready;
  assign start_fsms             = (state == S_PRIMED);
  assign last_inphase_packet    = cur_last_i;
  assign last_quadrature_packet = cur_last_q;
  assign inphase_bit            = cur_i[inphase_data_counter];
  assign quadrature_bit         = cur_q[quadrature_data_counter];

endmodule
